// File: rtl/pi1_memcpy_pkg.sv
// Shared pi1 bus opcodes and the memcpy engine's local state encoding.
package pi1_memcpy_pkg;

    localparam logic [1:0] PINOOP = 2'b00;
    localparam logic [1:0] PIWROP = 2'b01;
    localparam logic [1:0] PIRDOP = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RDREQ,
        ST_RDDAT,
        ST_WRREQ,
        ST_DONE
    } state_e;

    // A pi1 op is taken by the responder on any edge where it is valid and ready is high.
    function automatic logic op_accepted(input logic [1:0] op, input logic rdy);
        return (op != PINOOP) && rdy;
    endfunction

endpackage

// File: rtl/pi1_memcpy.sv
// pi1 bus initiator: copies len_i words src_i -> dst_i, or fills len_i words at dst_i
// with pattern_i. One operation in flight; all bus outputs are registered.
module pi1_memcpy
    import pi1_memcpy_pkg::*;
#(
    parameter int unsigned ARCHBITSZ = 32,
    localparam int unsigned ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     fill_i,
    input  logic [ADDRBITSZ-1:0]     src_i,
    input  logic [ADDRBITSZ-1:0]     dst_i,
    input  logic [ADDRBITSZ-1:0]     len_i,
    input  logic [ARCHBITSZ-1:0]     pattern_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [ADDRBITSZ-1:0]     remain_o,
    output logic [1:0]               pi1_op_o,
    output logic [ADDRBITSZ-1:0]     pi1_addr_o,
    output logic [ARCHBITSZ-1:0]     pi1_data_o,
    input  logic [ARCHBITSZ-1:0]     pi1_data_i,
    output logic [ARCHBITSZ/8-1:0]   pi1_sel_o,
    input  logic                     pi1_rdy_i
);

    state_e                 state_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   fill_q;
    logic [ADDRBITSZ-1:0]   src_q;
    logic [ADDRBITSZ-1:0]   dst_q;
    logic [ADDRBITSZ-1:0]   remain_q;
    logic [1:0]             op_q;
    logic [ADDRBITSZ-1:0]   addr_q;
    logic [ARCHBITSZ-1:0]   data_q;

    logic                   accept;
    logic [ADDRBITSZ-1:0]   src_d;
    logic [ADDRBITSZ-1:0]   dst_d;
    logic [ADDRBITSZ-1:0]   remain_d;

    assign accept   = op_accepted(op_q, pi1_rdy_i);
    assign src_d    = src_q + ADDRBITSZ'(1);
    assign dst_d    = dst_q + ADDRBITSZ'(1);
    assign remain_d = remain_q - ADDRBITSZ'(1);

    // Sequencer and registered bus/status outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fill_q   <= 1'b0;
            src_q    <= '0;
            dst_q    <= '0;
            remain_q <= '0;
            op_q     <= PINOOP;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (len_i == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            busy_q   <= 1'b1;
                            fill_q   <= fill_i;
                            src_q    <= src_i;
                            dst_q    <= dst_i;
                            remain_q <= len_i;
                            if (fill_i) begin
                                state_q <= ST_WRREQ;
                                op_q    <= PIWROP;
                                addr_q  <= dst_i;
                                data_q  <= pattern_i;
                            end else begin
                                state_q <= ST_RDREQ;
                                op_q    <= PIRDOP;
                                addr_q  <= src_i;
                            end
                        end
                    end
                end
                ST_RDREQ: begin
                    // Coming back from a write the bus idles one cycle before the next read.
                    if (op_q == PINOOP) begin
                        op_q   <= PIRDOP;
                        addr_q <= src_q;
                    end else if (accept) begin
                        op_q    <= PINOOP;
                        state_q <= ST_RDDAT;
                    end
                end
                ST_RDDAT: begin
                    if (pi1_rdy_i) begin
                        data_q  <= pi1_data_i;
                        op_q    <= PIWROP;
                        addr_q  <= dst_q;
                        state_q <= ST_WRREQ;
                    end
                end
                ST_WRREQ: begin
                    if (accept) begin
                        remain_q <= remain_d;
                        src_q    <= src_d;
                        dst_q    <= dst_d;
                        if (remain_q == ADDRBITSZ'(1)) begin
                            state_q <= ST_DONE;
                            op_q    <= PINOOP;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (fill_q) begin
                            addr_q <= dst_d;
                        end else begin
                            op_q    <= PINOOP;
                            state_q <= ST_RDREQ;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign remain_o   = remain_q;
    assign pi1_op_o   = op_q;
    assign pi1_addr_o = addr_q;
    assign pi1_data_o = data_q;
    assign pi1_sel_o  = '1;

endmodule

// File: tb/tb_pi1_memcpy.sv
// Directed bench for pi1_memcpy: a small pi1 memory responder with programmable ready
// delay, a transaction-level expectation queue checked every cycle, and literal pins.
module tb_pi1_memcpy;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam logic [1:0] OP_NOOP = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;

    typedef struct packed {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } bus_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          fill = 1'b0;
    logic [AW-1:0] src = '0;
    logic [AW-1:0] dst = '0;
    logic [AW-1:0] len = '0;
    logic [DW-1:0] pattern = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] remain;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] dout;
    logic [DW-1:0] din;
    logic [3:0]    sel;
    logic          rdy;

    always #5 clk = ~clk;

    pi1_memcpy #(.ARCHBITSZ(DW)) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .fill_i(fill),
        .src_i(src), .dst_i(dst), .len_i(len), .pattern_i(pattern),
        .busy_o(busy), .done_o(done), .remain_o(remain),
        .pi1_op_o(op), .pi1_addr_o(addr), .pi1_data_o(dout), .pi1_data_i(din),
        .pi1_sel_o(sel), .pi1_rdy_i(rdy)
    );

    // Responder: 256-word memory aliased on addr[7:0]; after each accepted op ready drops
    // for delay_cfg cycles. Read data is registered at acceptance.
    logic [DW-1:0] mem [0:255];
    int            delay_cfg = 0;
    int            dcnt = 0;
    logic [DW-1:0] rdata = '0;
    logic          pl_we = 1'b0;
    logic [7:0]    pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    assign rdy = (dcnt == 0);
    assign din = rdata;

    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        if (dcnt > 0) begin
            dcnt <= dcnt - 1;
        end else if (rst_n && op != OP_NOOP) begin
            if (op == OP_WR) mem[addr[7:0]] <= dout;
            else rdata <= mem[addr[7:0]];
            dcnt <= delay_cfg;
        end
    end

    // Model state: expected bus transactions, expected memory, done owed next cycle.
    bus_t          exp_q[$];
    logic [DW-1:0] ref_mem [0:255];
    logic          owe_done = 1'b0;
    logic          prev_hold = 1'b0;
    logic [63:0]   prev_bus = '0;
    logic          after_rd = 1'b0;
    int            n_rd = 0;
    int            n_wr = 0;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, want);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the transaction model.
    task automatic check();
        int   wrn;
        bus_t e;
        wrn = 0;
        foreach (exp_q[i]) if (exp_q[i].op == OP_WR) wrn++;
        chk("busy", 64'(busy), 64'(exp_q.size() != 0));
        chk("done", 64'(done), 64'(owe_done));
        owe_done = 1'b0;
        chk("remain", 64'(remain), 64'(wrn));
        chk("sel", 64'(sel), 64'(4'hF));
        if (prev_hold) chk("hold", {op, addr, dout}, prev_bus);
        if (after_rd) chk("noop_after_rd", 64'(op), 64'(OP_NOOP));
        after_rd = 1'b0;
        if (op != OP_NOOP && rdy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_op", 64'(op), 64'(OP_NOOP));
            end else begin
                e = exp_q.pop_front();
                chk("op", 64'(op), 64'(e.op));
                chk("addr", 64'(addr), 64'(e.addr));
                if (e.op == OP_WR) begin
                    chk("wdata", 64'(dout), 64'(e.data));
                    ref_mem[e.addr[7:0]] = e.data;
                    n_wr++;
                end else begin
                    after_rd = 1'b1;
                    n_rd++;
                end
                if (exp_q.size() == 0) owe_done = 1'b1;
            end
        end
        prev_hold = (op != OP_NOOP) && !rdy;
        prev_bus  = {op, addr, dout};
    endtask

    task automatic tick();
        @(negedge clk);
        check();
    endtask

    task automatic poke(input logic [7:0] a, input logic [DW-1:0] d);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = d;
        ref_mem[a] = d;
        tick();
        pl_we = 1'b0;
    endtask

    task automatic junk_inputs();
        fill    = 1'($urandom);
        src     = AW'($urandom);
        dst     = AW'($urandom);
        len     = AW'($urandom);
        pattern = $urandom;
    endtask

    // Launch one operation and run up to max_cyc cycles; cyc = cycle of done (0 if none).
    task automatic do_op(input logic f, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [AW-1:0] n, input logic [DW-1:0] p,
                         input int max_cyc, input bit want_done, output int cyc);
        logic [AW-1:0] a;
        bus_t          e;
        fill = f; src = s; dst = d; len = n; pattern = p; start = 1'b1;
        if (n == '0) owe_done = 1'b1;
        for (int i = 0; i < int'(n); i++) begin
            a = s + AW'(i);
            if (!f) begin
                e = '{op: OP_RD, addr: a, data: '0};
                exp_q.push_back(e);
            end
            e = '{op: OP_WR, addr: d + AW'(i), data: f ? p : ref_mem[a[7:0]]};
            exp_q.push_back(e);
        end
        cyc = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            tick();
            if (c == 1) begin
                start = 1'b0;
                junk_inputs();
            end
            if (done) begin
                cyc = c;
                break;
            end
        end
        if (want_done && cyc == 0) begin
            errors++;
            $display("FAIL timeout got no done expected done within %0d cycles", max_cyc);
        end
    endtask

    task automatic mem_compare(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk(name, 64'(bad), 64'd0);
    endtask

    int cyc;
    int rd0;
    int wr0;

    initial begin
        tick();
        tick();
        chk("rst_op", 64'(op), 64'd0);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_data", 64'(dout), 64'd0);
        chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
        chk("rst_remain", 64'(remain), 64'd0);
        rst_n = 1'b1;
        tick();

        // Copy, zero-delay responder.
        for (int i = 0; i < 4; i++) begin
            poke(8'h10 + 8'(i), 32'hA0 + 32'(i));
            poke(8'h40 + 8'(i), 32'h0);
        end
        do_op(1'b0, 30'h10, 30'h40, 30'd4, 32'h0, 40, 1'b1, cyc);
        chk("copy4_cycles", 64'(cyc), 64'd16);
        tick();
        for (int i = 0; i < 4; i++) chk("copy4_mem", 64'(mem[8'h40 + 8'(i)]), 64'(32'hA0 + 32'(i)));
        mem_compare("copy4_memall");

        // Fill, zero-delay: no reads, neighbour untouched.
        for (int i = 0; i < 4; i++) poke(8'h20 + 8'(i), 32'h11);
        rd0 = n_rd;
        do_op(1'b1, 30'h0, 30'h20, 30'd3, 32'hDEADBEEF, 40, 1'b1, cyc);
        chk("fill3_cycles", 64'(cyc), 64'd4);
        chk("fill3_no_rd", 64'(n_rd - rd0), 64'd0);
        tick();
        for (int i = 0; i < 3; i++) chk("fill3_mem", 64'(mem[8'h20 + 8'(i)]), 64'h0DEADBEEF);
        chk("fill3_untouched", 64'(mem[8'h23]), 64'h11);

        // Zero length: done one cycle after start, never busy, no bus op.
        do_op(1'b0, 30'h10, 30'h40, 30'd0, 32'h0, 10, 1'b1, cyc);
        chk("len0_cycles", 64'(cyc), 64'd1);
        for (int i = 0; i < 4; i++) tick();

        // Slow responder copy.
        delay_cfg = 3;
        poke(8'h50, 32'h0);
        poke(8'h51, 32'h0);
        rd0 = n_rd; wr0 = n_wr;
        do_op(1'b0, 30'h10, 30'h50, 30'd2, 32'h0, 60, 1'b1, cyc);
        chk("slowcopy_cycles", 64'(cyc), 64'd16);
        chk("slowcopy_rd", 64'(n_rd - rd0), 64'd2);
        chk("slowcopy_wr", 64'(n_wr - wr0), 64'd2);
        for (int i = 0; i < 6; i++) tick();
        chk("slowcopy_mem0", 64'(mem[8'h50]), 64'hA0);
        chk("slowcopy_mem1", 64'(mem[8'h51]), 64'hA1);

        // Slow responder fill wrapping the address space.
        poke(8'hFF, 32'h0);
        poke(8'h00, 32'h0);
        do_op(1'b1, 30'h0, 30'h3FFFFFFF, 30'd2, 32'hCAFEF00D, 40, 1'b1, cyc);
        chk("wrap_cycles", 64'(cyc), 64'd6);
        for (int i = 0; i < 6; i++) tick();
        chk("wrap_mem_top", 64'(mem[8'hFF]), 64'hCAFEF00D);
        chk("wrap_mem_zero", 64'(mem[8'h00]), 64'hCAFEF00D);
        mem_compare("wrap_memall");

        // Copy aborted by reset; a start while busy must be ignored.
        delay_cfg = 0;
        for (int i = 0; i < 4; i++) poke(8'h60 + 8'(i), 32'h0);
        poke(8'h80, 32'h77);
        do_op(1'b0, 30'h10, 30'h60, 30'd4, 32'h0, 1, 1'b0, cyc);
        fill = 1'b1; dst = 30'h80; len = 30'd1; pattern = 32'h12345678; start = 1'b1;
        tick();
        start = 1'b0;
        junk_inputs();
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b0;
        exp_q.delete();
        owe_done  = 1'b0;
        prev_hold = 1'b0;
        after_rd  = 1'b0;
        tick();
        chk("abort_op", 64'(op), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("abort_mem0", 64'(mem[8'h60]), 64'hA0);
        chk("abort_mem1", 64'(mem[8'h61]), 64'h0);
        chk("busy_start_ignored", 64'(mem[8'h80]), 64'h77);
        mem_compare("abort_memall");

        // Engine usable after abort.
        do_op(1'b1, 30'h0, 30'h61, 30'd1, 32'h55AA55AA, 20, 1'b1, cyc);
        chk("post_abort_cycles", 64'(cyc), 64'd2);
        tick();
        chk("post_abort_mem", 64'(mem[8'h61]), 64'h55AA55AA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
